// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, defaults and index-width helper for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int DMEM_DEFAULT_LATENCY = 4;
  localparam int DMEM_DEFAULT_WORDS = 256;
  function automatic int idx_w(input int words);
    return words > 1 ? $clog2(words) : 1;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: WORDS x 16 storage with a synchronous write port and a registered read port on one index
module dmem_array #(
  parameter int WORDS = 256,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);
  logic [15:0] mem [WORDS];
  // Storage is deliberately unreset so contents survive rst
  always_ff @(posedge clk)
    if (en && we) mem[idx] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (en && !we) rdata <= mem[idx];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency word responder that completes one request at a time with a data_valid pulse
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY = DMEM_DEFAULT_LATENCY,
  parameter int WORDS = DMEM_DEFAULT_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        busy
);
  localparam int IW = idx_w(WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
  localparam logic [15:0] USED = 16'((WORDS - 1) << 1);
  state_t state;
  logic [3:0] cnt;
  logic [IW-1:0] idx_q, idx, a_idx;
  logic wr_q, a_we, in_wait, accept, go_resp, unused_addr;
  logic [15:0] din_q, a_wd;
  assign idx = addr[IW:1];
  assign unused_addr = ^(addr & ~USED);
  assign in_wait = state == WAIT;
  assign busy = in_wait;
  assign data_valid = state == RESP;
  assign accept = enable && !busy;
  assign go_resp = (in_wait && cnt == '0) || (accept && LATENCY == 1);
  // With LATENCY=1 the array acts on the accept edge itself, before the latches hold the request
  assign a_idx = in_wait ? idx_q : idx;
  assign a_we = in_wait ? wr_q : wr;
  assign a_wd = in_wait ? din_q : data_in;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx_q <= '0;
      wr_q <= 1'b0;
      din_q <= '0;
    end else if (accept) begin
      state <= LATENCY == 1 ? RESP : WAIT;
      cnt <= CNT_LOAD;
      idx_q <= idx;
      wr_q <= wr;
      din_q <= data_in;
    end else if (in_wait) begin
      state <= cnt == '0 ? RESP : WAIT;
      cnt <= cnt == '0 ? cnt : cnt - 4'd1;
    end else state <= IDLE;
  dmem_array #(.WORDS(WORDS), .IW(IW)) u_array (
    .clk(clk),
    .rst(rst),
    .en(go_resp),
    .we(a_we),
    .idx(a_idx),
    .wdata(a_wd),
    .rdata(data_out)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of the responder at LATENCY=4 and LATENCY=1
module tb_dmem_responder;
  logic clk = 0, rst = 1;
  logic en = 0, wr = 0, dv, busy;
  logic [15:0] addr = 0, din = 0, dout;
  logic en1 = 0, wr1 = 0, dv1, busy1;
  logic [15:0] addr1 = 0, din1 = 0, dout1;
  int n_cmp = 0, n_err = 0;
  logic [15:0] q;
  logic [15:0] wa [3] = '{16'h0004, 16'h0007, 16'h0008};
  logic [15:0] wd [3] = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
  logic [15:0] ra [3] = '{16'h0006, 16'h0005, 16'h0009};
  logic [15:0] rd [3] = '{16'hBBBB, 16'hAAAA, 16'hCCCC};

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(4), .WORDS(256)) u_dut (
    .clk(clk), .rst(rst), .enable(en), .wr(wr), .addr(addr), .data_in(din),
    .data_out(dout), .data_valid(dv), .busy(busy)
  );
  dmem_responder #(.LATENCY(1), .WORDS(256)) u_dut1 (
    .clk(clk), .rst(rst), .enable(en1), .wr(wr1), .addr(addr1), .data_in(din1),
    .data_out(dout1), .data_valid(dv1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic w, input logic [15:0] a, input logic [15:0] d, output logic [15:0] r);
    int n;
    en = 1; wr = w; addr = a; din = d;
    tick;
    en = 0;
    n = 0;
    while (!dv && n < 20) begin
      tick;
      n++;
    end
    if (!dv) check("xfer_timeout", 16'(dv), 16'd1);
    r = dout;
    tick;
  endtask

  initial begin
    #12 rst = 0;
    tick;
    check("rst_busy", 16'(busy), 0);
    check("rst_dv", 16'(dv), 0);
    check("rst_dout", dout, 0);
    check("rst_dout1", dout1, 0);
    // write then read issued in the write's RESP cycle
    for (int c = 0; c <= 8; c++) begin
      en = c == 0 || c == 4; wr = c == 0; addr = 16'h0010; din = 16'hBEEF;
      check($sformatf("t1_busy_c%0d", c), 16'(busy), 16'((c >= 1 && c <= 3) || (c >= 5 && c <= 7)));
      check($sformatf("t1_dv_c%0d", c), 16'(dv), 16'(c == 4 || c == 8));
      if (c == 8) check("t1_dout", dout, 16'hBEEF);
      tick;
    end
    en = 0;
    tick;
    // request while busy is dropped
    xfer(1, 16'h0002, 16'h5555, q);
    for (int c = 0; c <= 5; c++) begin
      en = c == 0 || c == 2; wr = c == 2; addr = 16'h0002; din = 16'h1234;
      check($sformatf("t2_busy_c%0d", c), 16'(busy), 16'(c >= 1 && c <= 3));
      check($sformatf("t2_dv_c%0d", c), 16'(dv), 16'(c == 4));
      if (c == 4) check("t2_dout", dout, 16'h5555);
      tick;
    end
    en = 0;
    xfer(0, 16'h0002, 0, q);
    check("t2_reread", q, 16'h5555);
    // wrap-around and odd byte address
    xfer(1, 16'h0201, 16'hA5A5, q);
    xfer(0, 16'h0000, 0, q);
    check("t3_wrap", q, 16'hA5A5);
    // reset during an in-flight write
    xfer(1, 16'h0020, 16'h1111, q);
    en = 1; wr = 1; addr = 16'h0020; din = 16'h7777;
    tick;
    en = 0;
    tick;
    check("t4_busy_pre", 16'(busy), 1);
    rst = 1;
    #1;
    check("t4_busy", 16'(busy), 0);
    check("t4_dv", 16'(dv), 0);
    check("t4_dout", dout, 0);
    tick;
    rst = 0;
    tick;
    xfer(0, 16'h0020, 0, q);
    check("t4_read", q, 16'h1111);
    // LATENCY=1 back-to-back writes then reads
    for (int c = 0; c <= 3; c++) begin
      en1 = c < 3; wr1 = 1;
      if (c < 3) begin addr1 = wa[c]; din1 = wd[c]; end
      if (c > 0) check($sformatf("t5w_dv_c%0d", c), 16'(dv1), 1);
      check($sformatf("t5w_busy_c%0d", c), 16'(busy1), 0);
      check($sformatf("t5w_dout_c%0d", c), dout1, 0);
      tick;
    end
    for (int c = 0; c <= 3; c++) begin
      en1 = c < 3; wr1 = 0;
      if (c < 3) addr1 = ra[c];
      check($sformatf("t5r_dv_c%0d", c), 16'(dv1), 16'(c > 0));
      check($sformatf("t5r_busy_c%0d", c), 16'(busy1), 0);
      if (c > 0) check($sformatf("t5r_dout_c%0d", c), dout1, rd[c-1]);
      tick;
    end
    check("t5_dv_end", 16'(dv1), 0);
    check("t5_hold", dout1, 16'hCCCC);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder: the memory-side end of the CPU's data-memory request interface (enable / wr / addr / data_in, read data back on data_out). It accepts one word request at a time, holds it for a fixed LATENCY, then completes it with a one-cycle data_valid pulse. It replaces the single-cycle data memory when the pipeline moves to stalling memory accesses; the requester stalls while busy is high.

## Interface
- LATENCY, 4, cycles from request cycle to data_valid cycle; legal range 1..16
- WORDS, 256, number of 16-bit words stored; power of two, 2..32768
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  request present this cycle
- wr  in  1  1 = write, 0 = read; sampled with enable
- addr  in  16  byte address; word index = addr[log2(WORDS):1]
- data_in  in  16  write data; sampled with enable
- data_out  out  16  read data; valid when data_valid=1
- data_valid  out  1  one-cycle completion pulse, both reads and writes
- busy  out  1  a request is in flight; new requests are ignored

## Operation
- States: IDLE, WAIT, RESP.
- Accept rule: a request is accepted at the end of any cycle where enable=1 and busy=0. That includes IDLE and RESP.
- On accept, the block latches addr, wr and data_in. If LATENCY>1 it goes to WAIT and loads cnt=LATENCY-2. If LATENCY=1 it goes to RESP.
- WAIT: busy=1. cnt decrements each cycle. When cnt=0, the block goes to RESP at the next edge.
- RESP: data_valid=1 and busy=0.
  - If a new request is accepted, the block goes to WAIT (or RESP if LATENCY=1).
  - Otherwise it goes to IDLE.
- Read: data_out is loaded from mem[index] on the edge entering RESP. It holds that value until the next read completes.
- Write: mem[index] is written with the latched data on the edge entering RESP. data_out does not change.
- addr[0] is ignored; unaligned accesses act on the containing word. Address bits above log2(WORDS) are ignored (wrap-around).
- enable while busy=1 is dropped, not queued. The requester must hold or re-present the request.
- Reset:
  - Outputs: data_out=0, data_valid=0, busy=0.
  - State goes to IDLE and cnt=0; any in-flight request is discarded.
  - A write not yet committed is lost.
  - Array contents are not cleared; they are undefined after power-up and preserved across rst.

## Timing
- Request in cycle 0 (enable=1, busy=0):
  - busy=1 in cycles 1..LATENCY-1.
  - data_valid=1 in cycle LATENCY only.
- LATENCY=1: data_valid in cycle 1; busy never asserts.
- Maximum throughput: one request every LATENCY cycles, by issuing the next request in the data_valid cycle.
- Read-after-write: a read accepted in a write's RESP cycle returns the newly written data.
- A write commits on the edge ending cycle LATENCY-1.

## Structure
- Package dmem_pkg:
  - state typedef (IDLE, WAIT, RESP)
  - DMEM_DEFAULT_LATENCY=4 and DMEM_DEFAULT_WORDS=256
  - a localparam function for index width (clog2)
- Sub-module dmem_array:
  - WORDS×16 storage with a synchronous write port and a registered read port sharing one index.
  - Enable and write-enable are driven by the FSM on RESP entry.
  - No reset on the storage.
- The top level holds the FSM, cnt, the request latches, and the busy/data_valid decode.

## Test plan
- LATENCY=4: write 0xBEEF to addr 0x0010 in cycle 0, then read 0x0010 in cycle 4 (the RESP cycle). Expect data_valid in cycles 4 and 8, busy in cycles 1–3 and 5–7, and data_out=0xBEEF in cycle 8.
- Request while busy: read 0x0002 in cycle 0, then pulse enable with write 0x0002=0x1234 in cycle 2. The write must be ignored (only one data_valid, in cycle 4), and the old contents are returned.
- Wrap and alignment, WORDS=256: write 0xA5A5 to addr 0x0201, then read addr 0x0000. Expect 0xA5A5 (index 0, odd byte ignored).
- Reset mid-write: write 0x7777 to addr 0x0020 after first writing 0x1111 there, and assert rst in cycle 2. Expect busy=0, data_valid=0 and data_out=0 immediately (asynchronously). A later read of 0x0020 returns 0x1111.
- LATENCY=1 back-to-back reads on consecutive cycles: data_valid is high every cycle with the correct data, and busy stays 0 throughout.
